// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, time-field limits and widths for the alarm ring block.
package alarm_pkg;
  localparam int HOURS_MAX = 23;
  localparam int MINS_MAX  = 59;
  localparam int HOURS_W   = 5;
  localparam int MINS_W    = 6;
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/alarm_time_ring_if.sv
// alarm_time_ring_if: control inputs, clock time and alarm outputs of the alarm ring block.
interface alarm_time_ring_if;
  import alarm_pkg::*;
  logic               sec_tick;
  logic               alarm_mode;
  logic               alarm_on;
  logic               hours;
  logic               mins;
  logic [HOURS_W-1:0] cur_hours;
  logic [MINS_W-1:0]  cur_mins;
  logic               stop;
  logic               snooze;
  logic [HOURS_W-1:0] alm_hours;
  logic [MINS_W-1:0]  alm_mins;
  logic               ring;
  modport master (output sec_tick, alarm_mode, alarm_on, hours, mins, cur_hours, cur_mins, stop, snooze,
                  input alm_hours, alm_mins, ring);
  modport slave  (input sec_tick, alarm_mode, alarm_on, hours, mins, cur_hours, cur_mins, stop, snooze,
                  output alm_hours, alm_mins, ring);
endinterface

// File: rtl/alarm_wrap_inc.sv
// alarm_wrap_inc: registered counter that steps by one on inc_i and wraps from MAX back to zero.
module alarm_wrap_inc #(
  parameter int WIDTH = 5,
  parameter int MAX   = 23
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] val_o
);
  logic [WIDTH-1:0] val_q, val_d;
  always_comb val_d = !inc_i ? val_q : (val_q == WIDTH'(MAX)) ? '0 : val_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) val_q <= '0;
    else          val_q <= val_d;
  assign val_o = val_q;
endmodule

// File: rtl/alarm_time_ring.sv
// alarm_time_ring: holds the alarm time and rings on a rising time match; snooze via ALARM_SNOOZE_EN.
module alarm_time_ring
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input logic              clk,
  input logic              reset_n,
  alarm_time_ring_if.slave bus
);
  localparam int CW = $clog2(max2(RING_SECS, SNOOZE_SECS) + 1);
  localparam logic [CW-1:0] RING_LD = CW'(RING_SECS);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic match, match_q, trigger;
  alarm_wrap_inc #(.WIDTH(HOURS_W), .MAX(HOURS_MAX)) u_hours (
    .clk(clk), .reset_n(reset_n), .inc_i(bus.hours & bus.alarm_mode), .val_o(bus.alm_hours));
  alarm_wrap_inc #(.WIDTH(MINS_W), .MAX(MINS_MAX)) u_mins (
    .clk(clk), .reset_n(reset_n), .inc_i(bus.mins & bus.alarm_mode), .val_o(bus.alm_mins));
  assign match   = (bus.cur_hours == bus.alm_hours) && (bus.cur_mins == bus.alm_mins);
  assign trigger = match & ~match_q & bus.alarm_on & ~bus.alarm_mode;
  // match_q resets high so a 00:00 match already present at reset release is not an edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (trigger) begin
        state_d = RING;
        cnt_d   = RING_LD;
      end
    end else if (!bus.alarm_on || bus.alarm_mode || bus.stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
`ifdef ALARM_SNOOZE_EN
    else if (state_q == RING && bus.snooze) begin
      state_d = SNOOZE;
      cnt_d   = CW'(SNOOZE_SECS);
    end
`endif
    else if (bus.sec_tick) begin
      if (cnt_q == CW'(1)) begin
        state_d = (state_q == SNOOZE) ? RING : IDLE;
        cnt_d   = (state_q == SNOOZE) ? RING_LD : '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end
  always_comb bus.ring = (state_q == RING);
endmodule

// File: tb/tb_alarm_time_ring.sv
// tb_alarm_time_ring: randomized and directed stimulus scored against a queue-fed time/ring reference.
module tb_alarm_time_ring;
  localparam int RS = 3;
  localparam int SS = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  logic clk = 0;
  logic reset_n = 0;
  alarm_time_ring_if bus ();
  alarm_time_ring #(.RING_SECS(RS), .SNOOZE_SECS(SS)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic [4:0] h; logic [5:0] m; logic r;} exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic rn = 0, tk = 0, md = 0, on = 1, ph = 0, pm = 0, st = 0, sz = 0;
  logic [4:0] ch = 0;
  logic [5:0] cm = 0;
  int ah = 0, am = 0, phase = 0, left = 0;
  bit prev = 1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  // phase: 0 silent, 1 ringing, 2 snoozing; left counts remaining seconds
  task automatic model_step();
    bit match, trig;
    match = (int'(ch) == ah) && (int'(cm) == am);
    trig  = match && !prev && on && !md;
    if (phase == 0) begin
      if (trig) begin phase = 1; left = RS; end
    end else if (!on || md || st) phase = 0;
    else if (SNZ && phase == 1 && sz) begin phase = 2; left = SS; end
    else if (tk) begin
      if (left == 1) begin phase = (phase == 2) ? 1 : 0; left = RS; end
      else left--;
    end
    if (md && ph) ah = (ah + 1) % 24;
    if (md && pm) am = (am + 1) % 60;
    prev = match;
  endtask
  task automatic cyc();
    @(negedge clk);
    reset_n = rn;
    bus.sec_tick = tk; bus.alarm_mode = md; bus.alarm_on = on; bus.hours = ph; bus.mins = pm;
    bus.cur_hours = ch; bus.cur_mins = cm; bus.stop = st; bus.snooze = sz;
    if (!rn) begin ah = 0; am = 0; prev = 1; phase = 0; left = 0; end
    else model_step();
    q.push_back('{h: 5'(ah), m: 6'(am), r: (phase == 1)});
    tk = 0; ph = 0; pm = 0; st = 0; sz = 0;
  endtask
  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask
  task automatic tick_cycles(input int n);
    repeat (n) begin tk = 1; cyc(); cycles(3); end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alm_hours", int'(bus.alm_hours), int'(e.h));
        chk("alm_mins", int'(bus.alm_mins), int'(e.m));
        chk("ring", int'(bus.ring), int'(e.r));
      end
    end
  end
  initial begin
    bus.sec_tick = 0; bus.alarm_mode = 0; bus.alarm_on = 1; bus.hours = 0; bus.mins = 0;
    bus.cur_hours = 0; bus.cur_mins = 0; bus.stop = 0; bus.snooze = 0;
    cycles(3);
    rn = 1;
    cycles(100);
    md = 1;
    repeat (24) begin ph = 1; cyc(); end
    repeat (61) begin pm = 1; cyc(); end
    md = 0;
    repeat (5) begin ph = 1; pm = 1; cyc(); end
    md = 1;
    repeat (7) begin ph = 1; cyc(); end
    repeat (29) begin pm = 1; cyc(); end
    md = 0; ch = 7; cm = 29; cycles(3);
    cm = 30; cycles(2);
    tick_cycles(6);
    cycles(10);
    cm = 29; cycles(2); cm = 30; cycles(3);
    st = 1; cyc(); cycles(3);
    cm = 29; cycles(2); cm = 30; cycles(3);
    on = 0; cyc(); cycles(3); on = 1; cycles(5);
    cm = 29; cycles(2); cm = 30; cycles(2);
    tick_cycles(1);
    tk = 1; st = 1; cyc(); cycles(4);
    cm = 29; cycles(2); cm = 30; cycles(2);
    sz = 1; cyc();
    tick_cycles(7);
    md = 1;
    repeat (16) begin ph = 1; cyc(); end
    repeat (29) begin pm = 1; cyc(); end
    ph = 1; pm = 1; cyc();
    cycles(3);
    md = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 6 == 0) begin
        int sel;
        sel = $urandom_range(0, 2);
        if (sel == 0) begin ch = 5'(ah); cm = 6'(am); end
        else if (sel == 1) begin ch = 5'($urandom_range(0, 23)); cm = 6'($urandom_range(0, 59)); end
        else begin ch = 5'(ah); cm = 6'((am + 59) % 60); end
        md = ($urandom_range(0, 99) < 10);
        on = ($urandom_range(0, 9) != 0);
      end
      tk = ($urandom_range(0, 3) == 0);
      ph = ($urandom_range(0, 2) == 0);
      pm = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 29) == 0);
      sz = ($urandom_range(0, 14) == 0);
      rn = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rn = 1;
    cycles(2);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
